// File: rtl/ship_missile_ctrl_if.sv
// Bundles the key/vsync inputs and the ship/missile pool state that
// ship_missile_ctrl publishes to the video generator.
interface ship_missile_ctrl_if #(
  parameter int NMIS = 4
);
  logic                 vsync;
  logic                 keyleft;
  logic                 keyright;
  logic                 keyfire;
  logic [9:0]           ship_x;
  logic [NMIS-1:0]      missile_valid;
  logic [10*NMIS-1:0]   missile_x;
  logic [10*NMIS-1:0]   missile_y;
  logic                 busy;

  modport master (
    output vsync, keyleft, keyright, keyfire,
    input  ship_x, missile_valid, missile_x, missile_y, busy
  );

  modport slave (
    input  vsync, keyleft, keyright, keyfire,
    output ship_x, missile_valid, missile_x, missile_y, busy
  );
endinterface

// File: rtl/ship_missile_ctrl.sv
// Per-frame scheduler: on each vsync falling edge it moves the ship, ages the
// missile pool one slot per cycle, then tries to launch a missile.
module ship_missile_ctrl #(
  parameter int NMIS      = 4,
  parameter int SHIP_X0   = 315,
  parameter int SHIP_W    = 11,
  parameter int SHIP_Y    = 460,
  parameter int HACTIVE   = 640,
  parameter int SHIP_STEP = 2,
  parameter int MIS_STEP  = 4,
  parameter int MIS_LEN   = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic                clk,
  input  logic                reset,
  ship_missile_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIP, MIS, FIRE} state_e;

  localparam int              IDXW     = (NMIS > 1) ? $clog2(NMIS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NMIS - 1);
  localparam logic [9:0]      SHIP_MAX = 10'(HACTIVE - SHIP_W);
  localparam logic [9:0]      SHIP_RST = 10'(SHIP_X0);
  localparam logic [9:0]      STEP_S   = 10'(SHIP_STEP);
  localparam logic [9:0]      STEP_M   = 10'(MIS_STEP);
  localparam logic [9:0]      LAUNCH_Y = 10'(SHIP_Y - MIS_LEN);
  localparam logic [9:0]      HALF_W   = 10'(SHIP_W / 2);
  localparam logic [7:0]      CD_INIT  = 8'(COOLDOWN);

  state_e          state_q, state_d;
  logic            vsync_q;
  logic            kl_q, kl_d, kr_q, kr_d, kf_q, kf_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [9:0]      shipX_q, shipX_d;
  logic [NMIS-1:0] valid_q, valid_d;
  logic [9:0]      misX_q [NMIS];
  logic [9:0]      misX_d [NMIS];
  logic [9:0]      misY_q [NMIS];
  logic [9:0]      misY_d [NMIS];
  logic [7:0]      cd_q, cd_d;
  logic [10:0]     shipSum;
  logic            tick;
  logic            freeFound;
  logic [IDXW-1:0] freeIdx;

  assign tick = vsync_q & ~bus.vsync;

  // Lowest-index empty slot is the launch target.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = NMIS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        freeFound = 1'b1;
        freeIdx   = IDXW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kl_d    = kl_q;
    kr_d    = kr_q;
    kf_d    = kf_q;
    shipX_d = shipX_q;
    valid_d = valid_q;
    misX_d  = misX_q;
    misY_d  = misY_q;
    cd_d    = cd_q;
    shipSum = {1'b0, shipX_q} + {1'b0, STEP_S};
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          kl_d    = bus.keyleft;
          kr_d    = bus.keyright;
          kf_d    = bus.keyfire;
          state_d = SHIP;
        end
      end
      SHIP: begin
        if (kr_q && !kl_q)
          shipX_d = (shipSum > {1'b0, SHIP_MAX}) ? SHIP_MAX : shipSum[9:0];
        else if (kl_q && !kr_q)
          shipX_d = (shipX_q < STEP_S) ? 10'd0 : shipX_q - STEP_S;
        idx_d   = '0;
        state_d = MIS;
      end
      MIS: begin
        if (valid_q[idx_q]) begin
          if (misY_q[idx_q] < STEP_M) valid_d[idx_q] = 1'b0;
          else                        misY_d[idx_q]  = misY_q[idx_q] - STEP_M;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = FIRE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FIRE: begin
        // shipX_q already holds this frame's moved position here.
        if (kf_q && (cd_q == 8'd0) && freeFound) begin
          valid_d[freeIdx] = 1'b1;
          misX_d[freeIdx]  = shipX_q + HALF_W;
          misY_d[freeIdx]  = LAUNCH_Y;
          cd_d             = CD_INIT;
        end else if (cd_q != 8'd0) begin
          cd_d = cd_q - 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b1;
      kl_q    <= 1'b0;
      kr_q    <= 1'b0;
      kf_q    <= 1'b0;
      idx_q   <= '0;
      shipX_q <= SHIP_RST;
      valid_q <= '0;
      misX_q  <= '{default: '0};
      misY_q  <= '{default: '0};
      cd_q    <= '0;
    end else begin
      vsync_q <= bus.vsync;
      kl_q    <= kl_d;
      kr_q    <= kr_d;
      kf_q    <= kf_d;
      idx_q   <= idx_d;
      shipX_q <= shipX_d;
      valid_q <= valid_d;
      misX_q  <= misX_d;
      misY_q  <= misY_d;
      cd_q    <= cd_d;
    end
  end

  assign bus.ship_x        = shipX_q;
  assign bus.missile_valid = valid_q;
  assign bus.busy          = (state_q != IDLE);

  for (genvar g = 0; g < NMIS; g++) begin : g_pack
    assign bus.missile_x[10*g +: 10] = misX_q[g];
    assign bus.missile_y[10*g +: 10] = misY_q[g];
  end

endmodule

// File: tb/tb_ship_missile_ctrl.sv
// Bench for ship_missile_ctrl: a frame-level model applied whole at the end of
// each update, compared every cycle, plus pinned literal expectations.
module tb_ship_missile_ctrl;
  localparam int NMIS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ship_missile_ctrl_if #(.NMIS(NMIS)) bus();
  ship_missile_ctrl #(.NMIS(NMIS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int busyCycles;

  bit mStarted = 1'b0;
  bit mVsyncQ  = 1'b1;
  int busyLeft = 0;
  int mShip    = 315;
  int mCd      = 0;
  bit mKl, mKr, mKf;
  bit mValid [NMIS];
  int mX [NMIS];
  int mY [NMIS];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Whole-frame effect of one update: move, age the pool, maybe launch.
  function automatic void applyFrame();
    int slot;
    if (mKr && !mKl) mShip = (mShip + 2 > 629) ? 629 : mShip + 2;
    else if (mKl && !mKr) mShip = (mShip < 2) ? 0 : mShip - 2;
    for (int i = 0; i < NMIS; i++) begin
      if (mValid[i]) begin
        if (mY[i] < 4) mValid[i] = 1'b0;
        else           mY[i] = mY[i] - 4;
      end
    end
    slot = -1;
    for (int i = NMIS - 1; i >= 0; i--) if (!mValid[i]) slot = i;
    if (mKf && mCd == 0 && slot >= 0) begin
      mValid[slot] = 1'b1;
      mX[slot]     = mShip + 5;
      mY[slot]     = 456;
      mCd          = 8;
    end else if (mCd != 0) begin
      mCd = mCd - 1;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mStarted = 1'b1;
      mVsyncQ  = 1'b1;
      busyLeft = 0;
      mShip    = 315;
      mCd      = 0;
      for (int i = 0; i < NMIS; i++) begin
        mValid[i] = 1'b0;
        mX[i]     = 0;
        mY[i]     = 0;
      end
    end else begin
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) applyFrame();
      end else if (mVsyncQ && !bus.vsync) begin
        mKl      = bus.keyleft;
        mKr      = bus.keyright;
        mKf      = bus.keyfire;
        busyLeft = NMIS + 2;
      end
      mVsyncQ = bus.vsync;
    end
  end

  always @(negedge clk) begin
    if (mStarted) begin
      checkOutput("busy", int'(bus.busy), (busyLeft != 0) ? 1 : 0);
      if (busyLeft == 0) begin
        checkOutput("ship_x", int'(bus.ship_x), mShip);
        for (int i = 0; i < NMIS; i++) begin
          checkOutput($sformatf("valid[%0d]", i), int'(bus.missile_valid[i]), int'(mValid[i]));
          checkOutput($sformatf("missile_x[%0d]", i), int'(bus.missile_x[10*i +: 10]), mX[i]);
          checkOutput($sformatf("missile_y[%0d]", i), int'(bus.missile_y[10*i +: 10]), mY[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.busy === 1'b1) busyCycles++;
  endtask

  // One frame per iteration: a one-cycle vsync pulse, then nine quiet cycles.
  task automatic applyStimulus(input bit kl, input bit kr, input bit kf, input int frames);
    busyCycles = 0;
    for (int f = 0; f < frames; f++) begin
      bus.keyleft  = kl;
      bus.keyright = kr;
      bus.keyfire  = kf;
      bus.vsync    = 1'b0;
      step();
      bus.vsync = 1'b1;
      repeat (9) step();
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.vsync    = 1'b1;
    bus.keyleft  = 1'b0;
    bus.keyright = 1'b0;
    bus.keyfire  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset ship_x", int'(bus.ship_x), 315);
    checkOutput("reset valid", int'(bus.missile_valid), 0);
    checkOutput("reset busy", int'(bus.busy), 0);

    applyStimulus(0, 0, 0, 1);
    checkOutput("idle frame busy cycles", busyCycles, 6);
    checkOutput("idle frame ship_x", int'(bus.ship_x), 315);
    checkOutput("idle frame valid", int'(bus.missile_valid), 0);

    // Reset lands in the second MIS cycle of a frame that would launch.
    bus.keyfire = 1'b1;
    bus.vsync   = 1'b0;
    step();
    bus.vsync = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset       = 1'b0;
    bus.keyfire = 1'b0;
    checkOutput("mid reset busy", int'(bus.busy), 0);
    checkOutput("mid reset valid", int'(bus.missile_valid), 0);
    checkOutput("mid reset ship_x", int'(bus.ship_x), 315);
    repeat (5) step();
    applyStimulus(0, 0, 0, 1);
    checkOutput("post reset busy cycles", busyCycles, 6);
    checkOutput("post reset valid", int'(bus.missile_valid), 0);

    for (int t = 1; t <= 116; t++) begin
      applyStimulus(0, 0, 1, 1);
      case (t)
        1: begin
          checkOutput("fire t1 valid", int'(bus.missile_valid), 1);
          checkOutput("fire t1 x0", int'(bus.missile_x[9:0]), 320);
          checkOutput("fire t1 y0", int'(bus.missile_y[9:0]), 456);
        end
        2:   checkOutput("fire t2 y0", int'(bus.missile_y[9:0]), 452);
        9:   checkOutput("fire t9 valid", int'(bus.missile_valid), 1);
        10:  checkOutput("fire t10 valid", int'(bus.missile_valid), 3);
        19:  checkOutput("fire t19 valid", int'(bus.missile_valid), 7);
        28:  checkOutput("fire t28 valid", int'(bus.missile_valid), 15);
        114: checkOutput("fire t114 y0", int'(bus.missile_y[9:0]), 4);
        115: checkOutput("fire t115 y0", int'(bus.missile_y[9:0]), 0);
        116: begin
          checkOutput("relaunch valid", int'(bus.missile_valid), 15);
          checkOutput("relaunch y0", int'(bus.missile_y[9:0]), 456);
        end
        default: ;
      endcase
    end

    applyStimulus(0, 1, 0, 1);
    checkOutput("right first", int'(bus.ship_x), 317);
    applyStimulus(0, 1, 0, 199);
    checkOutput("right saturate", int'(bus.ship_x), 629);
    applyStimulus(1, 0, 0, 314);
    checkOutput("left to 1", int'(bus.ship_x), 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("left to 0", int'(bus.ship_x), 0);
    applyStimulus(1, 0, 0, 85);
    checkOutput("left hold 0", int'(bus.ship_x), 0);

    applyStimulus(0, 1, 0, 5);
    applyStimulus(1, 1, 0, 1);
    checkOutput("both keys", int'(bus.ship_x), 10);

    // Keys change right after the tick; the frame must use the captured values.
    bus.keyleft  = 1'b0;
    bus.keyright = 1'b0;
    bus.keyfire  = 1'b0;
    bus.vsync    = 1'b0;
    step();
    bus.vsync    = 1'b1;
    bus.keyright = 1'b1;
    repeat (9) step();
    bus.keyright = 1'b0;
    checkOutput("toggle ignored", int'(bus.ship_x), 10);

    for (int c = 0; c < 3000; c++) begin
      bus.vsync    = ($urandom_range(0, 5) != 0);
      bus.keyleft  = $urandom_range(0, 1) == 1;
      bus.keyright = $urandom_range(0, 1) == 1;
      bus.keyfire  = $urandom_range(0, 2) != 0;
      reset        = ($urandom_range(0, 299) == 0);
      step();
    end
    reset     = 1'b0;
    bus.vsync = 1'b1;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
